// File: rtl/lfmr_rx_datapath.sv
// UART receive timing/datapath primitives: reloadable strobe counter, bit-lane
// demux and a small math/compare unit, each with LATENCY optional output stages.
module lfmr_rx_datapath #(
  parameter int CNT_WIDTH  = 16,
  parameter int DMUX_WIDTH = 1,
  parameter int DMUX_COUNT = 8,
  parameter int MATH_WIDTH = 4,
  parameter int LATENCY    = 0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cnt_clr,
  input  logic                               cnt_en,
  input  logic [CNT_WIDTH-1:0]               cnt_reload,
  output logic                               cnt_strobe,
  input  logic [$clog2(DMUX_COUNT)-1:0]      dmux_sel,
  input  logic [DMUX_WIDTH-1:0]              dmux_in,
  output logic [DMUX_COUNT*DMUX_WIDTH-1:0]   dmux_out,
  input  logic                               math_clr,
  input  logic [MATH_WIDTH-1:0]              math_i1,
  input  logic [MATH_WIDTH-1:0]              math_i2,
  input  logic [MATH_WIDTH-1:0]              math_i3,
  output logic [MATH_WIDTH-1:0]              math_sum,
  output logic [MATH_WIDTH-1:0]              math_sub,
  output logic [MATH_WIDTH-1:0]              math_and,
  output logic [MATH_WIDTH-1:0]              math_or,
  output logic [MATH_WIDTH-1:0]              math_xor,
  output logic                               math_eq,
  output logic                               math_neq
);

  localparam int SEL_W = $clog2(DMUX_COUNT);
  localparam int DM_W  = DMUX_COUNT * DMUX_WIDTH;
  localparam int MR_W  = 5 * MATH_WIDTH + 2;

  logic [CNT_WIDTH-1:0] count;
  logic                 strobe_p0;
  logic [DM_W-1:0]      dmux_c;
  logic [MR_W-1:0]      math_c;
  logic [MR_W-1:0]      math_r;

  // Stage 0: counter register and its registered terminal-count strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      strobe_p0 <= 1'b0;
    end else if (cnt_clr) begin
      count     <= cnt_reload;
      strobe_p0 <= 1'b0;
    end else if (cnt_en) begin
      if (count == '0) begin
        count     <= cnt_reload;
        strobe_p0 <= 1'b1;
      end else begin
        count     <= count - CNT_WIDTH'(1);
        strobe_p0 <= 1'b0;
      end
    end else begin
      strobe_p0 <= 1'b0;
    end
  end

  // Out-of-range selects match no lane, leaving every lane zero
  always_comb begin
    dmux_c = '0;
    for (int k = 0; k < DMUX_COUNT; k++) begin
      if (dmux_sel == SEL_W'(k)) dmux_c[k*DMUX_WIDTH +: DMUX_WIDTH] = dmux_in;
    end
  end

  assign math_c = {math_i1 + math_i2, math_i1 - math_i2, math_i1 & math_i2,
                   math_i1 | math_i2, math_i1 ^ math_i2,
                   math_i1 == math_i3, math_i1 != math_i3};

  generate
    if (LATENCY == 0) begin : g_comb
      assign cnt_strobe = strobe_p0;
      assign dmux_out   = dmux_c;
      assign math_r     = math_c;
    end else begin : g_pipe
      logic            strobe_pn [LATENCY];
      logic [DM_W-1:0] dmux_pn   [LATENCY];
      logic [MR_W-1:0] math_pn   [LATENCY];

      // Stages 1..LATENCY: output delay line for strobe and demux
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < LATENCY; k++) begin
            strobe_pn[k] <= 1'b0;
            dmux_pn[k]   <= '0;
          end
        end else begin
          strobe_pn[0] <= strobe_p0;
          dmux_pn[0]   <= dmux_c;
          for (int k = 1; k < LATENCY; k++) begin
            strobe_pn[k] <= strobe_pn[k-1];
            dmux_pn[k]   <= dmux_pn[k-1];
          end
        end
      end

      // Stages 1..LATENCY: math delay line, flushable by math_clr
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < LATENCY; k++) math_pn[k] <= '0;
        end else if (math_clr) begin
          for (int k = 0; k < LATENCY; k++) math_pn[k] <= '0;
        end else begin
          math_pn[0] <= math_c;
          for (int k = 1; k < LATENCY; k++) math_pn[k] <= math_pn[k-1];
        end
      end

      assign cnt_strobe = strobe_pn[LATENCY-1];
      assign dmux_out   = dmux_pn[LATENCY-1];
      assign math_r     = math_pn[LATENCY-1];
    end
  endgenerate

  assign {math_sum, math_sub, math_and, math_or, math_xor, math_eq, math_neq} = math_r;

endmodule

// File: tb/tb_lfmr_rx_datapath.sv
// Directed bench: one LATENCY=0 and one LATENCY=1 instance driven by shared inputs.
module tb_lfmr_rx_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cnt_clr = 1'b0, cnt_en = 1'b0;
  logic [15:0] cnt_reload = '0;
  logic [2:0] dmux_sel = '0;
  logic [0:0] dmux_in = '0;
  logic       math_clr = 1'b0;
  logic [3:0] math_i1 = '0, math_i2 = '0, math_i3 = '0;

  logic       s0, s1;
  logic [7:0] d0, d1;
  logic [3:0] m0_sum, m0_sub, m0_and, m0_or, m0_xor;
  logic [3:0] m1_sum, m1_sub, m1_and, m1_or, m1_xor;
  logic       m0_eq, m0_neq, m1_eq, m1_neq;
  logic [21:0] mv0, mv1;

  int checks = 0;
  int failures = 0;

  assign mv0 = {m0_sum, m0_sub, m0_and, m0_or, m0_xor, m0_eq, m0_neq};
  assign mv1 = {m1_sum, m1_sub, m1_and, m1_or, m1_xor, m1_eq, m1_neq};

  always #5 clk = ~clk;

  lfmr_rx_datapath #(.LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .cnt_reload(cnt_reload),
    .cnt_strobe(s0), .dmux_sel(dmux_sel), .dmux_in(dmux_in), .dmux_out(d0),
    .math_clr(math_clr), .math_i1(math_i1), .math_i2(math_i2), .math_i3(math_i3),
    .math_sum(m0_sum), .math_sub(m0_sub), .math_and(m0_and), .math_or(m0_or),
    .math_xor(m0_xor), .math_eq(m0_eq), .math_neq(m0_neq));

  lfmr_rx_datapath #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .cnt_clr(cnt_clr), .cnt_en(cnt_en), .cnt_reload(cnt_reload),
    .cnt_strobe(s1), .dmux_sel(dmux_sel), .dmux_in(dmux_in), .dmux_out(d1),
    .math_clr(math_clr), .math_i1(math_i1), .math_i2(math_i2), .math_i3(math_i3),
    .math_sum(m1_sum), .math_sub(m1_sub), .math_and(m1_and), .math_or(m1_or),
    .math_xor(m1_xor), .math_eq(m1_eq), .math_neq(m1_neq));

  localparam logic [21:0] MV_A = {4'h0, 4'hE, 4'h1, 4'hF, 4'hE, 1'b1, 1'b0};
  localparam logic [21:0] MV_B = {4'h4, 4'h2, 4'h1, 4'h3, 4'h2, 1'b0, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    math_i1 = 4'h3; math_i2 = 4'h1; math_i3 = 4'h8;
    dmux_sel = 3'd2; dmux_in = 1'b1;
    tick(); tick();
    checks++; if (s0 !== 1'b0 || s1 !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b%b exp=00", s0, s1); end
    checks++; if (dut0.count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", dut0.count); end
    checks++; if (d0 !== 8'h04) begin failures++; $display("FAIL reset_dmux_comb got=%h exp=04", d0); end
    checks++; if (d1 !== 8'h00) begin failures++; $display("FAIL reset_dmux_reg got=%h exp=00", d1); end
    checks++; if (mv0 !== MV_B) begin failures++; $display("FAIL reset_math_comb got=%h exp=%h", mv0, MV_B); end
    checks++; if (mv1 !== 22'd0) begin failures++; $display("FAIL reset_math_reg got=%h exp=0", mv1); end
  endtask

  task automatic test_period();
    logic e0, e1;
    rst = 1'b0; cnt_clr = 1'b1; cnt_reload = 16'd4; cnt_en = 1'b0;
    tick();
    checks++; if (dut0.count !== 16'd4 || s0 !== 1'b0) begin failures++; $display("FAIL period_clr got=%0d/%b exp=4/0", dut0.count, s0); end
    cnt_clr = 1'b0; cnt_en = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      e0 = (i % 5 == 0);
      e1 = (i >= 6) && (i % 5 == 1);
      checks++; if (s0 !== e0) begin failures++; $display("FAIL period_strobe cyc=%0d got=%b exp=%b", i, s0, e0); end
      checks++; if (s1 !== e1) begin failures++; $display("FAIL period_strobe_lat1 cyc=%0d got=%b exp=%b", i, s1, e1); end
    end
  endtask

  task automatic test_gated();
    logic [15:0] exp_cnt [12] = '{16'd1, 16'd1, 16'd0, 16'd0, 16'd2, 16'd2,
                                  16'd1, 16'd1, 16'd0, 16'd0, 16'd2, 16'd2};
    logic [11:0] exp_stb = 12'b0100_0001_0000;  // bit i: strobe after cycle i
    cnt_clr = 1'b1; cnt_reload = 16'd2; cnt_en = 1'b0;
    tick();
    cnt_clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cnt_en = (i % 2 == 0);
      tick();
      checks++; if (dut0.count !== exp_cnt[i]) begin failures++; $display("FAIL gated_count cyc=%0d got=%0d exp=%0d", i, dut0.count, exp_cnt[i]); end
      checks++; if (s0 !== exp_stb[i]) begin failures++; $display("FAIL gated_strobe cyc=%0d got=%b exp=%b", i, s0, exp_stb[i]); end
    end
  endtask

  task automatic test_clear_reset();
    cnt_clr = 1'b1; cnt_reload = 16'd3; cnt_en = 1'b1;
    tick();
    cnt_clr = 1'b0;
    tick(); tick();
    checks++; if (dut0.count !== 16'd1) begin failures++; $display("FAIL clr_precount got=%0d exp=1", dut0.count); end
    cnt_clr = 1'b1;
    tick();
    checks++; if (dut0.count !== 16'd3 || s0 !== 1'b0) begin failures++; $display("FAIL clr_reload got=%0d/%b exp=3/0", dut0.count, s0); end
    cnt_clr = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++; if (s0 !== (i == 4)) begin failures++; $display("FAIL clr_restart cyc=%0d got=%b exp=%b", i, s0, (i == 4)); end
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (s0 !== 1'b0 || dut0.count !== 16'd0) begin failures++; $display("FAIL async_reset got=%b/%0d exp=0/0", s0, dut0.count); end
    tick();
    rst = 1'b0; cnt_en = 1'b0;
  endtask

  task automatic test_demux();
    logic [7:0] exp;
    for (int s = 0; s < 9; s++) begin
      dmux_sel = (s < 8) ? 3'(s) : 3'd3;
      dmux_in  = (s < 8) ? 1'b1 : 1'b0;
      exp = (s < 8) ? (8'h01 << s) : 8'h00;
      #1;
      checks++; if (d0 !== exp) begin failures++; $display("FAIL demux_comb sel=%0d got=%h exp=%h", dmux_sel, d0, exp); end
      tick();
      checks++; if (d1 !== exp) begin failures++; $display("FAIL demux_lat1 sel=%0d got=%h exp=%h", dmux_sel, d1, exp); end
    end
  endtask

  task automatic test_math();
    math_i1 = 4'hF; math_i2 = 4'h1; math_i3 = 4'hF;
    #1;
    checks++; if (mv0 !== MV_A) begin failures++; $display("FAIL math_a_comb got=%h exp=%h", mv0, MV_A); end
    checks++; if (mv1 === MV_A) begin failures++; $display("FAIL math_a_early got=%h exp=not %h", mv1, MV_A); end
    tick();
    checks++; if (mv1 !== MV_A) begin failures++; $display("FAIL math_a_lat1 got=%h exp=%h", mv1, MV_A); end
    math_i1 = 4'h3; math_i2 = 4'h1; math_i3 = 4'h8;
    #1;
    checks++; if (mv0 !== MV_B) begin failures++; $display("FAIL math_b_comb got=%h exp=%h", mv0, MV_B); end
    tick();
    checks++; if (mv1 !== MV_B) begin failures++; $display("FAIL math_b_lat1 got=%h exp=%h", mv1, MV_B); end
    math_clr = 1'b1;
    tick();
    checks++; if (mv1 !== 22'd0) begin failures++; $display("FAIL math_clr_reg got=%h exp=0", mv1); end
    checks++; if (mv0 !== MV_B) begin failures++; $display("FAIL math_clr_comb got=%h exp=%h", mv0, MV_B); end
    math_clr = 1'b0;
    tick();
    checks++; if (mv1 !== MV_B) begin failures++; $display("FAIL math_after_clr got=%h exp=%h", mv1, MV_B); end
  endtask

  initial begin
    test_reset();
    test_period();
    test_gated();
    test_clear_reset();
    test_demux();
    test_math();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
